// File: rtl/note_scroller_pkg.sv
// rtl/note_scroller_pkg.sv - shared geometry, colours and helpers for the note scroller
package note_scroller_pkg;

  localparam int LANES              = 4;
  localparam int LANE_W             = 16;
  localparam int ROWS               = 7;
  localparam int COLS               = 64;
  localparam int PIX_W              = COLS * 3;
  localparam int SCROLL_DIV_DEFAULT = 2500000;

  localparam logic [2:0] COLOR_RED   = 3'b100;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  // Index by lane number: lane 0 red, 1 green, 2 blue, 3 white.
  localparam logic [LANES-1:0][2:0] LANE_COLORS = {COLOR_WHITE, COLOR_BLUE, COLOR_GREEN, COLOR_RED};

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Scores stick at 255 rather than wrapping back to a small number.
  function automatic logic [7:0] sat_add8(input logic [7:0] c, input logic [2:0] n);
    logic [8:0] s;
    s = {1'b0, c} + {6'b000000, n};
    return s[8] ? 8'hff : s[7:0];
  endfunction

endpackage

// File: rtl/note_spawn_fifo.sv
// rtl/note_spawn_fifo.sv - small queue of pending top-row lane masks
module note_spawn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next-state for storage, pointers and occupancy; guarded so overflow/underflow are impossible.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // State registers with synchronous reset emptying the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/note_scroller.sv
// rtl/note_scroller.sv - scrolling 7x4 note field with hit judging and pixel expansion
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int SCROLL_DIV = SCROLL_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spawn_valid,
  input  logic [3:0]       spawn_lanes,
  output logic             spawn_ready,
  input  logic [3:0]       btn,
  output logic             step,
  output logic [3:0]       hit,
  output logic [3:0]       miss,
  output logic [7:0]       hit_count,
  output logic [7:0]       miss_count,
  output logic [PIX_W-1:0] notesMap0,
  output logic [PIX_W-1:0] notesMap1,
  output logic [PIX_W-1:0] notesMap2,
  output logic [PIX_W-1:0] notesMap3,
  output logic [PIX_W-1:0] notesMap4,
  output logic [PIX_W-1:0] notesMap5,
  output logic [PIX_W-1:0] notesMap6
);

  localparam int TW = $clog2(SCROLL_DIV);

  logic [TW-1:0]                tcnt_q, tcnt_d;
  logic                         step_int;
  logic                         step_q, step_d;
  logic [LANES-1:0]             hit_q, hit_d;
  logic [LANES-1:0]             miss_q, miss_d;
  logic [7:0]                   hit_count_q, hit_count_d;
  logic [7:0]                   miss_count_q, miss_count_d;
  logic [ROWS-1:0][LANES-1:0]   field_q, field_d;
  logic [ROWS-1:0][PIX_W-1:0]   pix;
  logic                         fifo_full, fifo_empty;
  logic [LANES-1:0]             fifo_head;

  // Ready depends only on FIFO occupancy, never on spawn_valid.
  assign spawn_ready = !fifo_full;

  note_spawn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LANES)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (spawn_valid),
    .push_data (spawn_lanes),
    .pop       (step_int),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scroll timer: advances only while enabled, step_int marks the wrap cycle.
  always_comb begin
    step_int = 1'b0;
    tcnt_d   = tcnt_q;
    if (enable) begin
      if (tcnt_q == TW'(SCROLL_DIV - 1)) begin
        step_int = 1'b1;
        tcnt_d   = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  // Judge presses against the hit row first, then score leftovers as misses and shift on a step.
  always_comb begin
    field_d = field_q;
    hit_d   = '0;
    miss_d  = '0;
    step_d  = step_int;
    if (enable) begin
      hit_d            = btn & field_q[ROWS-1];
      field_d[ROWS-1]  = field_q[ROWS-1] & ~btn;
      if (step_int) begin
        miss_d = field_d[ROWS-1];
        for (int r = ROWS - 1; r > 0; r--) field_d[r] = field_q[r-1];
        field_d[0] = fifo_empty ? '0 : fifo_head;
      end
    end
    hit_count_d  = sat_add8(hit_count_q, popcount4(hit_d));
    miss_count_d = sat_add8(miss_count_q, popcount4(miss_d));
  end

  // Game state registers; reset clears the field, timer, pulses and scores together.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q       <= '0;
      step_q       <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      field_q      <= '0;
    end else begin
      tcnt_q       <= tcnt_d;
      step_q       <= step_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      field_q      <= field_d;
    end
  end

  // Each lane is 16 columns wide with its first and last column left dark as a separator.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int LANE = c / LANE_W;
      localparam int POS  = c % LANE_W;
      if (POS == 0 || POS == LANE_W - 1) begin : g_border
        assign pix[r][c*3 +: 3] = 3'b000;
      end else begin : g_body
        assign pix[r][c*3 +: 3] = field_q[r][LANE] ? LANE_COLORS[LANE] : 3'b000;
      end
    end
  end

  assign step       = step_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign notesMap0  = pix[0];
  assign notesMap1  = pix[1];
  assign notesMap2  = pix[2];
  assign notesMap3  = pix[3];
  assign notesMap4  = pix[4];
  assign notesMap5  = pix[5];
  assign notesMap6  = pix[6];

endmodule
